mic_capture_scheduler: RTL and testbench

- Sequences sampling of the three PMOD microphones at a fixed audio rate and delivers one tagged sample per sample tick to the downstream audio path.
- Sits between the switch-driven mic selection in the top level and the per-mic capture front ends.
- Two modes: fixed selection driven by the switch code, or round-robin scanning.
- Handles mux settling, a request/valid handshake with timeout, and overrun detection.

---
 rtl/mic_capture_scheduler.sv | 154 +++++++++++++++
 tb/tb_mic_capture_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mic_capture_scheduler.sv
// mic_capture_scheduler: paces capture of the three PMOD mics at the audio
// sample rate. Each sample tick picks a target mic (switch code or
// round-robin), settles the capture mux when the selection changes, runs a
// request/valid handshake with a timeout, and delivers one tagged sample.
module mic_capture_scheduler #(
    parameter int SAMPLE_PERIOD  = 2268,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = 16
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              scan_en,
    input  logic [1:0]        sel_code,
    output logic [1:0]        mic_sel,
    output logic              mic_req,
    input  logic              mic_valid,
    input  logic [DATA_W-1:0] mic_data,
    output logic [DATA_W-1:0] sample_out,
    output logic [1:0]        sample_id,
    output logic              sample_valid,
    output logic              timeout_err,
    output logic              overrun_err,
    input  logic              err_clr
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] MUTE_ID = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_REQ} state_t;

    state_t              r_state, w_state_nxt;
    logic [TW-1:0]       r_tick_cnt;
    logic [SW-1:0]       r_settle_cnt;
    logic [OW-1:0]       r_to_cnt;
    logic [1:0]          r_mic_sel, r_rr_ptr, r_sample_id;
    logic [DATA_W-1:0]   r_sample_out;
    logic                r_sample_valid, r_timeout_err, r_overrun_err;

    logic                w_tick, w_mute, w_capture, w_timeout, w_settle_done;
    logic [1:0]          w_sel_dec, w_target;

    assign w_tick        = (r_tick_cnt == TW'(SAMPLE_PERIOD - 1));
    assign w_capture     = (r_state == S_REQ) && mic_valid;
    // A response arriving on the last allowed cycle still counts as a capture.
    assign w_timeout     = (r_state == S_REQ) && !mic_valid &&
                           (r_to_cnt == OW'(TIMEOUT_CYCLES - 1));
    assign w_settle_done = (r_state == S_SETTLE) &&
                           (r_settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign w_target      = scan_en ? r_rr_ptr : w_sel_dec;
    assign w_mute        = (w_target == MUTE_ID);

    // Switch code to mic index; 2'b01 means mute.
    always_comb begin
        case (sel_code)
            2'b10:   w_sel_dec = 2'd0;
            2'b11:   w_sel_dec = 2'd1;
            2'b00:   w_sel_dec = 2'd2;
            default: w_sel_dec = MUTE_ID;
        endcase
    end

    // Free-running sample-rate counter, independent of the FSM.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    // FSM state register.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state; ticks outside IDLE are dropped (flagged as overrun).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_tick && !w_mute)
                          w_state_nxt = (w_target == r_mic_sel) ? S_REQ : S_SETTLE;
            S_SETTLE: if (w_settle_done) w_state_nxt = S_REQ;
            S_REQ:    if (w_capture || w_timeout) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; mic_req decodes state so reset drops it without a clock.
    always_comb begin
        mic_req = (r_state == S_REQ);
    end

    // Settle and timeout counters restart whenever their state is left.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + SW'(1) : '0;
            r_to_cnt     <= (r_state == S_REQ)    ? r_to_cnt + OW'(1)     : '0;
        end
    end

    // Mux select, delivered sample and round-robin pointer.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_mic_sel      <= '0;
            r_rr_ptr       <= '0;
            r_sample_out   <= '0;
            r_sample_id    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (r_state == S_IDLE && w_tick) begin
                if (w_mute) begin
                    r_sample_out   <= '0;
                    r_sample_id    <= MUTE_ID;
                    r_sample_valid <= 1'b1;
                end else begin
                    r_mic_sel <= w_target;
                end
            end
            if (w_capture) begin
                r_sample_out   <= mic_data;
                r_sample_id    <= r_mic_sel;
                r_sample_valid <= 1'b1;
            end
            if ((w_capture || w_timeout) && scan_en)
                r_rr_ptr <= (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (err_clr) r_timeout_err <= 1'b0;
            if (w_tick && r_state != S_IDLE) r_overrun_err <= 1'b1;
            else if (err_clr)                r_overrun_err <= 1'b0;
        end
    end

    assign mic_sel      = r_mic_sel;
    assign sample_out   = r_sample_out;
    assign sample_id    = r_sample_id;
    assign sample_valid = r_sample_valid;
    assign timeout_err  = r_timeout_err;
    assign overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_mic_capture_scheduler.sv
// Bench for mic_capture_scheduler: per-tick vector table on a default-rate
// instance, plus hand sequences for error clear, async reset and overrun
// (the latter on a short-period instance).
module tb_mic_capture_scheduler;
    localparam int P     = 2268;
    localparam int P2    = 20;
    localparam int WIN   = 100;
    localparam int NEVER = 255;
    localparam int NV    = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, scan_en, mic_valid, err_clr;
    logic [1:0]  sel_code, mic_sel, sample_id;
    logic [15:0] mic_data, sample_out;
    logic        mic_req, sample_valid, timeout_err, overrun_err;

    logic        rst2_n, scan2, mvalid2, clr2;
    logic [1:0]  sel2, o2_sel, o2_id;
    logic [15:0] mdata2, o2_out;
    logic        o2_req, o2_sv, o2_to, o2_ovr;

    mic_capture_scheduler u_dut (
        .clk_100mhz(clk), .rst_n(rst_n), .scan_en(scan_en), .sel_code(sel_code),
        .mic_sel(mic_sel), .mic_req(mic_req), .mic_valid(mic_valid), .mic_data(mic_data),
        .sample_out(sample_out), .sample_id(sample_id), .sample_valid(sample_valid),
        .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
    );

    mic_capture_scheduler #(.SAMPLE_PERIOD(P2)) u_ovr (
        .clk_100mhz(clk), .rst_n(rst2_n), .scan_en(scan2), .sel_code(sel2),
        .mic_sel(o2_sel), .mic_req(o2_req), .mic_valid(mvalid2), .mic_data(mdata2),
        .sample_out(o2_out), .sample_id(o2_id), .sample_valid(o2_sv),
        .timeout_err(o2_to), .overrun_err(o2_ovr), .err_clr(clr2)
    );

    typedef struct {
        logic        scan;
        logic [1:0]  sel;
        logic [1:0]  sel_mid;  // sel_code driven two cycles after the tick
        int          dly;      // front-end answer delay after first mic_req
        logic [15:0] data;
        logic        stray;    // extra mic_valid pulse outside REQ
        logic [1:0]  e_sel;
        int          e_req;    // cycle after tick of first mic_req (0 = none)
        int          e_reqc;
        int          e_nv;
        int          e_vrel;
        logic [1:0]  e_id;
        logic [15:0] e_out;
        logic        e_to;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    initial begin
        vec_t vec [NV];
        vec_t tv;
        int   r0, reqc, nv, vrel, nsv, nreq2;
        logic [1:0] sel_at;

        //            scan  sel    mid    dly    data      stray  e_sel e_req reqc nv vrel e_id   e_out     e_to
        vec[0]  = '{1'b0, 2'b11, 2'b11, 3,     16'h1234, 1'b1, 2'd1, 17, 4,  1, 21, 2'd1, 16'h1234, 1'b0};
        vec[1]  = '{1'b0, 2'b11, 2'b00, 3,     16'hBEEF, 1'b0, 2'd1, 1,  4,  1, 5,  2'd1, 16'hBEEF, 1'b0};
        vec[2]  = '{1'b1, 2'b11, 2'b11, 3,     16'h0000, 1'b1, 2'd0, 17, 4,  1, 21, 2'd0, 16'h0000, 1'b0};
        vec[3]  = '{1'b1, 2'b11, 2'b11, 3,     16'h0001, 1'b0, 2'd1, 17, 4,  1, 21, 2'd1, 16'h0001, 1'b0};
        vec[4]  = '{1'b1, 2'b11, 2'b11, 3,     16'h0002, 1'b0, 2'd2, 17, 4,  1, 21, 2'd2, 16'h0002, 1'b0};
        vec[5]  = '{1'b1, 2'b11, 2'b11, 3,     16'h0000, 1'b0, 2'd0, 17, 4,  1, 21, 2'd0, 16'h0000, 1'b0};
        vec[6]  = '{1'b0, 2'b10, 2'b10, 0,     16'hA5A5, 1'b0, 2'd0, 1,  1,  1, 2,  2'd0, 16'hA5A5, 1'b0};
        vec[7]  = '{1'b0, 2'b01, 2'b01, 0,     16'hFFFF, 1'b0, 2'd0, 0,  0,  1, 1,  2'd3, 16'h0000, 1'b0};
        vec[8]  = '{1'b0, 2'b01, 2'b10, 0,     16'hFFFF, 1'b0, 2'd0, 0,  0,  1, 1,  2'd3, 16'h0000, 1'b0};
        vec[9]  = '{1'b0, 2'b00, 2'b00, 5,     16'h7FFF, 1'b0, 2'd2, 17, 6,  1, 23, 2'd2, 16'h7FFF, 1'b0};
        vec[10] = '{1'b0, 2'b00, 2'b00, NEVER, 16'h1357, 1'b0, 2'd2, 1,  64, 0, 0,  2'd2, 16'h7FFF, 1'b1};
        vec[11] = '{1'b0, 2'b00, 2'b00, 1,     16'h8000, 1'b0, 2'd2, 1,  2,  1, 3,  2'd2, 16'h8000, 1'b1};
        vec[12] = '{1'b1, 2'b00, 2'b00, 2,     16'h1111, 1'b0, 2'd1, 17, 3,  1, 20, 2'd1, 16'h1111, 1'b1};

        rst_n = 1'b0; scan_en = 1'b0; sel_code = 2'b11; mic_valid = 1'b0;
        mic_data = '0; err_clr = 1'b0;
        rst2_n = 1'b0; scan2 = 1'b0; sel2 = 2'b10; mvalid2 = 1'b0; mdata2 = '0; clr2 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", 32'({mic_sel, mic_req, sample_out, sample_id, sample_valid,
                                  timeout_err, overrun_err}), 32'd0);
        rst_n = 1'b1;
        k = 0;

        for (int v = 0; v < NV; v++) begin
            tv = vec[v];
            scan_en  = tv.scan;
            sel_code = tv.sel;
            run_to((v + 1) * P - 1);
            r0 = 0; reqc = 0; nv = 0; vrel = 0; sel_at = 2'd0;
            for (int rel = 1; rel <= WIN; rel++) begin
                step();
                if (rel == 1) sel_at = mic_sel;
                if (rel == 2) sel_code = tv.sel_mid;
                if (mic_req) begin
                    reqc++;
                    if (r0 == 0) r0 = rel;
                end
                if (sample_valid) begin
                    nv++;
                    if (vrel == 0) vrel = rel;
                end
                mic_valid = (mic_req && r0 != 0 && tv.dly != NEVER && rel == r0 + tv.dly) ||
                            (tv.stray && rel == 5);
                mic_data  = tv.data;
            end
            mic_valid = 1'b0;
            chk($sformatf("v%0d mic_sel", v),       32'(sel_at),      32'(tv.e_sel));
            chk($sformatf("v%0d first req", v),     32'(r0),          32'(tv.e_req));
            chk($sformatf("v%0d req cycles", v),    32'(reqc),        32'(tv.e_reqc));
            chk($sformatf("v%0d valid count", v),   32'(nv),          32'(tv.e_nv));
            chk($sformatf("v%0d valid cycle", v),   32'(vrel),        32'(tv.e_vrel));
            chk($sformatf("v%0d sample_id", v),     32'(sample_id),   32'(tv.e_id));
            chk($sformatf("v%0d sample_out", v),    32'(sample_out),  32'(tv.e_out));
            chk($sformatf("v%0d timeout_err", v),   32'(timeout_err), 32'(tv.e_to));
        end
        chk("no overrun at normal rate", 32'(overrun_err), 32'd0);

        // err_clr drops the sticky timeout flag
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("timeout_err cleared", 32'(timeout_err), 32'd0);

        // async reset while mic_req is high (mic1 -> mic0 settles, REQ from rel 17)
        scan_en  = 1'b0;
        sel_code = 2'b10;
        run_to(14 * P - 1);
        repeat (20) step();
        chk("req before reset", 32'(mic_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({mic_sel, mic_req, sample_out, sample_id, sample_valid,
                                        timeout_err, overrun_err}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run_to(P - 1);
        chk("no req before first tick", 32'(mic_req), 32'd0);
        step();
        chk("req one cycle after first tick", 32'(mic_req), 32'd1);
        mic_valid = 1'b1;
        mic_data  = 16'h4242;
        step();
        mic_valid = 1'b0;
        chk("post-reset sample", 32'({sample_valid, sample_id, sample_out}),
            32'({1'b1, 2'd0, 16'h4242}));

        // overrun on a short period: answer after 30 cycles spans a tick
        @(negedge clk);
        rst2_n = 1'b1;
        nsv = 0; nreq2 = 0;
        for (int j = 1; j <= 78; j++) begin
            @(posedge clk);
            #1;
            mvalid2 = (j == 50) || (j == 62);
            mdata2  = (j == 50) ? 16'hCAFE : 16'h0BAD;
            clr2    = (j == 39) || (j == 76);
            if (o2_req) nreq2++;
            if (o2_sv)  nsv++;
            if (j == 20) chk("ovr req after tick", 32'(o2_req), 32'd1);
            if (j == 39) chk("ovr flag before tick", 32'(o2_ovr), 32'd0);
            if (j == 40) chk("ovr set wins over clear", 32'(o2_ovr), 32'd1);
            if (j == 51) chk("ovr in-flight sample", 32'({o2_sv, o2_id, o2_out}),
                             32'({1'b1, 2'd0, 16'hCAFE}));
            if (j == 63) chk("ovr next sample", 32'({o2_sv, o2_id, o2_out}),
                             32'({1'b1, 2'd0, 16'h0BAD}));
            if (j == 77) chk("ovr cleared", 32'(o2_ovr), 32'd0);
        end
        mvalid2 = 1'b0;
        clr2    = 1'b0;
        chk("ovr valid count", 32'(nsv), 32'd2);
        chk("ovr req cycles", 32'(nreq2), 32'd34);
        chk("ovr no timeout", 32'(o2_to), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
